// File: rtl/mmu_utlb.sv
// Micro-TLB in front of one joint-TLB search port: 1-cycle hit/unmapped, 2-cycle walk on miss.
// Optional MMU_UTLB_PERF_CNT_EN adds saturating hit/miss counters (perf_hit, perf_miss).
module mmu_utlb #(
   parameter int ENTRIES = 4,
   parameter int TLBNUM  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [31:0]               req_vaddr,
   input  logic                      req_store,
   output logic                      resp_valid,
   output logic [31:0]               resp_paddr,
   output logic                      resp_uncached,
   output logic                      resp_refill,
   output logic                      resp_invalid,
   output logic                      resp_modify,
   output logic                      resp_store,
   input  logic                      flush,
   input  logic [31:0]               r_cp0_EntryHi,
   input  logic [31:0]               r_cp0_Config,
   output logic [18:0]               s_vpn,
   output logic                      s_odd,
   output logic [7:0]                s_asid,
   input  logic                      s_found,
   input  logic [$clog2(TLBNUM)-1:0] s_index,
   input  logic [19:0]               s_pfn,
   input  logic [2:0]                s_c,
   input  logic                      s_d,
   input  logic                      s_v
`ifdef MMU_UTLB_PERF_CNT_EN
   ,
   output logic [31:0]               perf_hit,
   output logic [31:0]               perf_miss
`endif
);

   localparam int IW = $clog2(ENTRIES);

   typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;

   state_t state, state_nxt;

   logic [ENTRIES-1:0] e_valid;
   logic [ENTRIES-1:0] e_g;
   logic [19:0]        e_vpn  [ENTRIES];
   logic [7:0]         e_asid [ENTRIES];
   logic [19:0]        e_pfn  [ENTRIES];
   logic [2:0]         e_c    [ENTRIES];
   logic [ENTRIES-1:0] e_d;

   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] hit_idx, free_idx, fill_idx;
   logic          hit, has_free;
   logic          accept, unmapped, start_walk, fill_en;

   logic [31:0] lat_vaddr;
   logic        lat_store;
   logic [7:0]  lat_asid;

   logic        w_ok, w_d;
   logic [19:0] w_pfn;
   logic [2:0]  w_c;

   logic        rv_n, unc_n, rf_n, inv_n, mod_n, st_n;
   logic [31:0] pa_n;

   logic unused_bits;
   assign unused_bits = ^{s_index, r_cp0_EntryHi[31:8], r_cp0_Config[31:3]};

   assign req_ready  = (state == IDLE) & ~rst;
   assign accept     = req_valid & req_ready;
   assign unmapped   = (req_vaddr[31:30] == 2'b10);
   assign start_walk = accept & ~unmapped & ~hit;

   assign s_vpn  = lat_vaddr[31:13];
   assign s_odd  = lat_vaddr[12];
   assign s_asid = lat_asid;

   // Descending scans so the lowest matching / lowest free index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (e_valid[i] && e_vpn[i] == req_vaddr[31:12] &&
             (e_g[i] || e_asid[i] == r_cp0_EntryHi[7:0])) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      has_free = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!e_valid[i]) begin
            has_free = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   assign fill_idx = has_free ? free_idx : rr_ptr;
   assign fill_en  = (state == RESP) & w_ok & ~flush;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_walk) state_nxt = WALK;
         WALK:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Response is staged one edge ahead: hits at accept, walks at the end of WALK.
   always_comb begin
      rv_n  = 1'b0;
      pa_n  = 32'd0;
      unc_n = 1'b0;
      rf_n  = 1'b0;
      inv_n = 1'b0;
      mod_n = 1'b0;
      st_n  = 1'b0;
      if (state == IDLE && accept) begin
         st_n = req_store;
         if (unmapped) begin
            rv_n  = 1'b1;
            pa_n  = {3'b000, req_vaddr[28:0]};
            unc_n = req_vaddr[29] | (r_cp0_Config[2:0] == 3'd2);
         end else if (hit) begin
            rv_n  = 1'b1;
            mod_n = req_store & ~e_d[hit_idx];
            if (!mod_n) begin
               pa_n  = {e_pfn[hit_idx], req_vaddr[11:0]};
               unc_n = (e_c[hit_idx] == 3'd2);
            end
         end
      end else if (state == WALK) begin
         rv_n = 1'b1;
         st_n = lat_store;
         if (!s_found) begin
            rf_n = 1'b1;
         end else if (!s_v) begin
            inv_n = 1'b1;
         end else begin
            mod_n = lat_store & ~s_d;
            if (!mod_n) begin
               pa_n  = {s_pfn, lat_vaddr[11:0]};
               unc_n = (s_c == 3'd2);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid    <= 1'b0;
         resp_paddr    <= 32'd0;
         resp_uncached <= 1'b0;
         resp_refill   <= 1'b0;
         resp_invalid  <= 1'b0;
         resp_modify   <= 1'b0;
         resp_store    <= 1'b0;
      end else begin
         resp_valid    <= rv_n;
         resp_paddr    <= pa_n;
         resp_uncached <= unc_n;
         resp_refill   <= rf_n;
         resp_invalid  <= inv_n;
         resp_modify   <= mod_n;
         resp_store    <= st_n;
      end
   end

   always_ff @(posedge clk) begin
      if (start_walk) begin
         lat_vaddr <= req_vaddr;
         lat_store <= req_store;
         lat_asid  <= r_cp0_EntryHi[7:0];
      end
      if (state == WALK) begin
         w_pfn <= s_pfn;
         w_c   <= s_c;
         w_d   <= s_d;
      end
   end

   // A flush seen during WALK cancels the pending fill.
   always_ff @(posedge clk) begin
      if (rst)                 w_ok <= 1'b0;
      else if (state == WALK)  w_ok <= s_found & s_v & ~flush;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_valid <= '0;
         rr_ptr  <= '0;
      end else if (flush) begin
         e_valid <= '0;
      end else if (fill_en) begin
         e_valid[fill_idx] <= 1'b1;
         if (!has_free) rr_ptr <= rr_ptr + 1'b1;
      end
   end

   // The search port does not export G, so every fill is ASID-tagged.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         e_vpn[fill_idx]  <= lat_vaddr[31:12];
         e_asid[fill_idx] <= lat_asid;
         e_g[fill_idx]    <= 1'b0;
         e_pfn[fill_idx]  <= w_pfn;
         e_c[fill_idx]    <= w_c;
         e_d[fill_idx]    <= w_d;
      end
   end

`ifdef MMU_UTLB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         perf_hit  <= 32'd0;
         perf_miss <= 32'd0;
      end else begin
         if (accept && !unmapped && hit && perf_hit != 32'hFFFF_FFFF)
            perf_hit <= perf_hit + 32'd1;
         if (start_walk && perf_miss != 32'hFFFF_FFFF)
            perf_miss <= perf_miss + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mmu_utlb.sv
// Directed bench for mmu_utlb (ENTRIES=4): bypass, walk/fill, exceptions, replacement, flush, reset.
module tb_mmu_utlb;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_vaddr;
   logic        req_store;
   logic        resp_valid;
   logic [31:0] resp_paddr;
   logic        resp_uncached, resp_refill, resp_invalid, resp_modify, resp_store;
   logic        flush;
   logic [31:0] r_cp0_EntryHi, r_cp0_Config;
   logic [18:0] s_vpn;
   logic        s_odd;
   logic [7:0]  s_asid;
   logic        s_found;
   logic [3:0]  s_index;
   logic [19:0] s_pfn;
   logic [2:0]  s_c;
   logic        s_d, s_v;

   int total = 0;
   int passes = 0;
   int lat;
   logic [31:0] r_paddr;
   logic        r_unc, r_rf, r_inv, r_mod, r_st;
   logic [18:0] w_vpn;
   logic        w_odd;
   logic [7:0]  w_asid;

   always #5 clk = ~clk;

   mmu_utlb #(.ENTRIES(4), .TLBNUM(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_store(req_store),
      .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_uncached(resp_uncached),
      .resp_refill(resp_refill), .resp_invalid(resp_invalid), .resp_modify(resp_modify),
      .resp_store(resp_store), .flush(flush),
      .r_cp0_EntryHi(r_cp0_EntryHi), .r_cp0_Config(r_cp0_Config),
      .s_vpn(s_vpn), .s_odd(s_odd), .s_asid(s_asid),
      .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Issue one request (optionally with flush in the accept cycle); measure latency to resp_valid.
   task automatic issue(input logic [31:0] va, input logic st, input logic fl);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      req_vaddr = va;
      req_store = st;
      req_valid = 1'b1;
      flush     = fl;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      w_vpn  = s_vpn;
      w_odd  = s_odd;
      w_asid = s_asid;
      lat = 1;
      while (!resp_valid && lat < 6) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r_paddr = resp_paddr;
      r_unc   = resp_uncached;
      r_rf    = resp_refill;
      r_inv   = resp_invalid;
      r_mod   = resp_modify;
      r_st    = resp_store;
   endtask

   task automatic jtlb(input logic found, input logic v, input logic [19:0] pfn,
                       input logic [2:0] c, input logic d);
      s_found = found;
      s_v     = v;
      s_pfn   = pfn;
      s_c     = c;
      s_d     = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0; flush = 1'b0;
      r_cp0_EntryHi = 32'h5; r_cp0_Config = 32'h3; s_index = '0;
      jtlb(1'b0, 1'b0, 20'h0, 3'd0, 1'b0);

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_paddr", resp_paddr, 32'h0);

      // Unmapped bypass
      issue(32'hA000_1234, 1'b0, 1'b0);
      chk("kseg1_lat", 32'(lat), 32'd1);
      chk("kseg1_paddr", r_paddr, 32'h0000_1234);
      chk("kseg1_unc", 32'(r_unc), 32'd1);
      chk("kseg1_exc", {29'd0, r_rf, r_inv, r_mod}, 32'd0);
      @(posedge clk); #1;
      chk("strobe_one_cycle", 32'(resp_valid), 32'd0);
      issue(32'h8000_0010, 1'b0, 1'b0);
      chk("kseg0_paddr", r_paddr, 32'h0000_0010);
      chk("kseg0_cached", 32'(r_unc), 32'd0);
      r_cp0_Config = 32'h2;
      issue(32'h8000_0020, 1'b0, 1'b0);
      chk("kseg0_k0_unc", 32'(r_unc), 32'd1);
      r_cp0_Config = 32'h3;

      // Miss walk then hit
      jtlb(1'b1, 1'b1, 20'h01F00, 3'd3, 1'b1);
      issue(32'h0040_2008, 1'b0, 1'b0);
      chk("miss_lat", 32'(lat), 32'd2);
      chk("miss_paddr", r_paddr, 32'h01F0_0008);
      chk("miss_unc", 32'(r_unc), 32'd0);
      chk("walk_vpn", 32'(w_vpn), 32'h201);
      chk("walk_odd", 32'(w_odd), 32'd0);
      chk("walk_asid", 32'(w_asid), 32'd5);
      s_pfn = 20'hFFFFF;
      issue(32'h0040_2008, 1'b0, 1'b0);
      chk("hit_lat", 32'(lat), 32'd1);
      chk("hit_paddr", r_paddr, 32'h01F0_0008);

      // Uncached fill with d=0, then store modify
      jtlb(1'b1, 1'b1, 20'h00ABC, 3'd2, 1'b0);
      issue(32'h0050_3004, 1'b0, 1'b0);
      chk("fill2_lat", 32'(lat), 32'd2);
      chk("fill2_paddr", r_paddr, 32'h00AB_C004);
      chk("fill2_unc", 32'(r_unc), 32'd1);
      issue(32'h0050_3010, 1'b1, 1'b0);
      chk("mod_lat", 32'(lat), 32'd1);
      chk("mod_flag", 32'(r_mod), 32'd1);
      chk("mod_store", 32'(r_st), 32'd1);
      chk("mod_paddr", r_paddr, 32'h0);
      chk("mod_unc", 32'(r_unc), 32'd0);

      // Refill and invalid exceptions never fill
      jtlb(1'b0, 1'b0, 20'h0, 3'd3, 1'b1);
      issue(32'h0060_0000, 1'b0, 1'b0);
      chk("refill_lat", 32'(lat), 32'd2);
      chk("refill_flag", 32'(r_rf), 32'd1);
      chk("refill_paddr", r_paddr, 32'h0);
      issue(32'h0060_0000, 1'b0, 1'b0);
      chk("refill_again_lat", 32'(lat), 32'd2);
      jtlb(1'b1, 1'b0, 20'h0, 3'd3, 1'b1);
      issue(32'h0061_0000, 1'b0, 1'b0);
      chk("invalid_flag", 32'(r_inv), 32'd1);
      chk("invalid_norefill", 32'(r_rf), 32'd0);

      // Replacement: e2, e3 fill free slots, fifth page evicts entry 0
      jtlb(1'b1, 1'b1, 20'h12345, 3'd3, 1'b1);
      issue(32'h0070_0000, 1'b0, 1'b0);
      chk("fill3_lat", 32'(lat), 32'd2);
      issue(32'h0070_1000, 1'b0, 1'b0);
      chk("fill4_lat", 32'(lat), 32'd2);
      issue(32'h0070_2000, 1'b0, 1'b0);
      chk("fill5_lat", 32'(lat), 32'd2);
      jtlb(1'b0, 1'b0, 20'h0, 3'd3, 1'b1);
      issue(32'h0040_2008, 1'b0, 1'b0);
      chk("evicted_miss", 32'(lat), 32'd2);
      issue(32'h0050_3000, 1'b0, 1'b0);
      chk("page2_hit", 32'(lat), 32'd1);
      issue(32'h0070_0000, 1'b0, 1'b0);
      chk("page3_hit", 32'(lat), 32'd1);
      issue(32'h0070_1000, 1'b0, 1'b0);
      chk("page4_hit", 32'(lat), 32'd1);
      issue(32'h0070_2ABC, 1'b0, 1'b0);
      chk("page5_hit", 32'(lat), 32'd1);
      chk("page5_paddr", r_paddr, 32'h1234_5ABC);

      // ASID mismatch misses
      r_cp0_EntryHi = 32'h6;
      issue(32'h0070_2000, 1'b0, 1'b0);
      chk("asid6_miss", 32'(lat), 32'd2);
      chk("asid6_walk", 32'(w_asid), 32'd6);
      r_cp0_EntryHi = 32'h5;
      issue(32'h0070_2000, 1'b0, 1'b0);
      chk("asid5_hit", 32'(lat), 32'd1);

      // Flush during RESP: response delivered, no fill
      jtlb(1'b1, 1'b1, 20'h0BEEF, 3'd3, 1'b1);
      issue(32'h0080_0004, 1'b0, 1'b0);
      chk("flushresp_lat", 32'(lat), 32'd2);
      chk("flushresp_paddr", r_paddr, 32'h0BEE_F004);
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      issue(32'h0080_0004, 1'b0, 1'b0);
      chk("after_flush_miss", 32'(lat), 32'd2);
      issue(32'h0070_0000, 1'b0, 1'b0);
      chk("flush_cleared_all", 32'(lat), 32'd2);

      // Flush coincident with a hit still answers from the old entry
      issue(32'h0080_0004, 1'b0, 1'b1);
      chk("flushhit_lat", 32'(lat), 32'd1);
      chk("flushhit_paddr", r_paddr, 32'h0BEE_F004);
      jtlb(1'b0, 1'b0, 20'h0, 3'd3, 1'b1);
      issue(32'h0080_0004, 1'b0, 1'b0);
      chk("flushhit_then_miss", 32'(lat), 32'd2);

      // Reset during WALK
      jtlb(1'b1, 1'b1, 20'h0BEEF, 3'd3, 1'b1);
      issue(32'h0080_0004, 1'b0, 1'b0);
      chk("prefill_lat", 32'(lat), 32'd2);
      @(negedge clk);
      while (!req_ready) @(negedge clk);
      req_vaddr = 32'h0090_0000; req_store = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rstwalk_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("rstwalk_no_resp2", 32'(resp_valid), 32'd0);
      chk("rstwalk_ready", 32'(req_ready), 32'd1);
      jtlb(1'b0, 1'b0, 20'h0, 3'd3, 1'b1);
      issue(32'h0080_0004, 1'b0, 1'b0);
      chk("rstwalk_entries_clear", 32'(lat), 32'd2);
      chk("rstwalk_refill", 32'(r_rf), 32'd1);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
